// File: rtl/wb_slave_pid_regs_if.sv
// Wishbone slave-side bundle between the interconnect and the PID register bank.
// Handshake: a request is taken when cyc&stb are high and no response is in flight; exactly one of ack/err answers it one cycle later.
interface wb_slave_pid_regs_if #(
  parameter int ADR_W = 16
);
  logic [ADR_W-1:0] wbs_adr_i;
  logic             wbs_we_i;
  logic             wbs_cyc_i;
  logic             wbs_stb_i;
  logic [31:0]      wbs_dat_i;
  logic [31:0]      wbs_dat_o;
  logic             wbs_ack_o;
  logic             wbs_err_o;

  modport master (
    output wbs_adr_i, wbs_we_i, wbs_cyc_i, wbs_stb_i, wbs_dat_i,
    input  wbs_dat_o, wbs_ack_o, wbs_err_o
  );

  modport slave (
    input  wbs_adr_i, wbs_we_i, wbs_cyc_i, wbs_stb_i, wbs_dat_i,
    output wbs_dat_o, wbs_ack_o, wbs_err_o
  );
endinterface

// File: rtl/wb_slave_pid_regs.sv
// PID configuration register bank: staged gains/setpoint committed atomically on a PV write,
// with captured PID result and status read-back over a single-cycle-latency Wishbone slave.
module wb_slave_pid_regs #(
  parameter int ADR_W = 16,
  parameter int CNT_W = 16
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  wb_slave_pid_regs_if.slave  wbs,
  output logic [31:0]         kp_o,
  output logic [31:0]         ki_o,
  output logic [31:0]         kd_o,
  output logic [31:0]         sp_o,
  output logic [31:0]         pv_o,
  output logic                sample_o,
  input  logic [31:0]         pid_result_i,
  input  logic                pid_done_i
);

  logic [31:0]      kp_stg_q, ki_stg_q, kd_stg_q, sp_stg_q;
  logic [31:0]      kp_q, ki_q, kd_q, sp_q, pv_q;
  logic [31:0]      result_q, dat_q, dat_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             busy_q, busy_d, rvalid_q, rvalid_d;
  logic             ack_q, err_q, sample_q;

  logic       accept, addr_ok, bad, ok;
  logic [2:0] idx;
  logic [15:0] count16;
  logic       stg_wr, pv_wr, status_rd;

  assign accept  = wbs.wbs_cyc_i && wbs.wbs_stb_i && !ack_q && !err_q;
  assign count16 = 16'(count_q);

  always_comb begin
    idx     = wbs.wbs_adr_i[4:2];
    addr_ok = (wbs.wbs_adr_i[1:0] == 2'b00) && (wbs.wbs_adr_i <= ADR_W'(24));
    // RESULT and STATUS (index 5, 6) are read-only; writing them is an error.
    bad       = !addr_ok || (wbs.wbs_we_i && (idx >= 3'd5));
    ok        = accept && !bad;
    stg_wr    = ok && wbs.wbs_we_i && (idx < 3'd4);
    pv_wr     = ok && wbs.wbs_we_i && (idx == 3'd4);
    status_rd = ok && !wbs.wbs_we_i && (idx == 3'd6);
  end

  always_comb begin
    dat_d = 32'h0;
    if (ok && !wbs.wbs_we_i) begin
      case (idx)
        3'd0:    dat_d = kp_stg_q;
        3'd1:    dat_d = ki_stg_q;
        3'd2:    dat_d = kd_stg_q;
        3'd3:    dat_d = sp_stg_q;
        3'd4:    dat_d = pv_q;
        3'd5:    dat_d = result_q;
        3'd6:    dat_d = {count16, 14'b0, busy_q, rvalid_q};
        default: dat_d = 32'h0;
      endcase
    end
  end

  // A new sample dominates a coincident completion; a completion dominates a status-read clear.
  always_comb begin
    busy_d = busy_q;
    if (pid_done_i) busy_d = 1'b0;
    if (pv_wr)      busy_d = 1'b1;
    rvalid_d = rvalid_q;
    if (status_rd)  rvalid_d = 1'b0;
    if (pid_done_i) rvalid_d = 1'b1;
    count_d = pv_wr ? count_q + 1'b1 : count_q;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      kp_stg_q <= '0; ki_stg_q <= '0; kd_stg_q <= '0; sp_stg_q <= '0;
      kp_q     <= '0; ki_q     <= '0; kd_q     <= '0; sp_q     <= '0;
      pv_q     <= '0;
      result_q <= '0;
      dat_q    <= '0;
      count_q  <= '0;
      busy_q   <= 1'b0;
      rvalid_q <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      sample_q <= 1'b0;
    end else begin
      ack_q    <= ok;
      err_q    <= accept && bad;
      sample_q <= pv_wr;
      dat_q    <= dat_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
      rvalid_q <= rvalid_d;
      if (pid_done_i) result_q <= pid_result_i;
      if (stg_wr) begin
        case (idx[1:0])
          2'd0:    kp_stg_q <= wbs.wbs_dat_i;
          2'd1:    ki_stg_q <= wbs.wbs_dat_i;
          2'd2:    kd_stg_q <= wbs.wbs_dat_i;
          default: sp_stg_q <= wbs.wbs_dat_i;
        endcase
      end
      if (pv_wr) begin
        pv_q <= wbs.wbs_dat_i;
        kp_q <= kp_stg_q;
        ki_q <= ki_stg_q;
        kd_q <= kd_stg_q;
        sp_q <= sp_stg_q;
      end
    end
  end

  assign wbs.wbs_ack_o = ack_q;
  assign wbs.wbs_err_o = err_q;
  assign wbs.wbs_dat_o = dat_q;
  assign kp_o     = kp_q;
  assign ki_o     = ki_q;
  assign kd_o     = kd_q;
  assign sp_o     = sp_q;
  assign pv_o     = pv_q;
  assign sample_o = sample_q;

endmodule
